// File: rtl/display_pkg.sv
// Shared types and constants for the BCD counter / seven-segment display path.
package display_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } debounce_state_e;

endpackage

// File: rtl/bcd_counter_4digit_if.sv
// Board-side signal bundle of the BCD counter: raw buttons and switches in, BCD digits out.
interface bcd_counter_4digit_if;
    import display_pkg::*;

    logic                        inc_btn;
    logic                        dec_btn;
    logic                        load_btn;
    logic [NUM_DIGITS*BCD_W-1:0] load_val;
    logic [NUM_DIGITS*BCD_W-1:0] digits;
    logic                        wrapped;

    modport master (
        output inc_btn, dec_btn, load_btn, load_val,
        input  digits, wrapped
    );

    modport slave (
        input  inc_btn, dec_btn, load_btn, load_val,
        output digits, wrapped
    );

endinterface

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, 4-state debounce FSM and
// a single-cycle press pulse on the debounced rising edge.
module button_debounce
    import display_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    // The Nth consecutive cycle is reached when the counter (started at 0) hits N-2.
    localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = DEBOUNCE_BITS'((1 << DEBOUNCE_BITS) - 2);

    logic [1:0]               sync_q;
    logic                     synced;
    debounce_state_e          state_q, state_d;
    logic [DEBOUNCE_BITS-1:0] count_q, count_d;
    logic                     level_q, level_d;
    logic                     press_q, press_d;

    assign synced = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            count_q <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        press_d = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (synced) begin
                    state_d = WAIT_HI;
                    count_d = '0;
                end
            end
            WAIT_HI: begin
                if (!synced) begin
                    state_d = STABLE_LO;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    count_d = count_q + DEBOUNCE_BITS'(1);
                end
            end
            STABLE_HI: begin
                if (!synced) begin
                    state_d = WAIT_LO;
                    count_d = '0;
                end
            end
            WAIT_LO: begin
                if (synced) begin
                    state_d = STABLE_HI;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                end else begin
                    count_d = count_q + DEBOUNCE_BITS'(1);
                end
            end
            default: state_d = STABLE_LO;
        endcase
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/bcd_counter_4digit.sv
// Four-digit BCD up/down counter driven by debounced inc/dec/load buttons;
// load has priority, simultaneous inc and dec cancel.
module bcd_counter_4digit
    import display_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 17
) (
    input  logic                 clock,
    input  logic                 reset,
    bcd_counter_4digit_if.slave  bus
);

    logic inc_level, dec_level, load_level;
    logic inc_p, dec_p, load_p;

    button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_inc_db (
        .clock(clock), .reset(reset), .raw(bus.inc_btn),  .level(inc_level),  .press(inc_p)
    );
    button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_dec_db (
        .clock(clock), .reset(reset), .raw(bus.dec_btn),  .level(dec_level),  .press(dec_p)
    );
    button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_load_db (
        .clock(clock), .reset(reset), .raw(bus.load_btn), .level(load_level), .press(load_p)
    );

    logic [NUM_DIGITS*BCD_W-1:0] digits_q, digits_d;
    logic                        wrapped_q, wrapped_d;
    logic                        carry;
    bcd_t                        dig;

    always_comb begin
        digits_d  = digits_q;
        wrapped_d = wrapped_q;
        carry     = 1'b1;
        dig       = '0;
        if (load_p) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = bus.load_val[i*BCD_W +: BCD_W];
                digits_d[i*BCD_W +: BCD_W] = (dig > BCD_MAX) ? BCD_MAX : dig;
            end
            wrapped_d = 1'b0;
        end else if (inc_p ^ dec_p) begin
            // Ripple from the least significant digit; carry doubles as borrow.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = digits_q[i*BCD_W +: BCD_W];
                if (carry) begin
                    if (inc_p) begin
                        if (dig == BCD_MAX) begin
                            digits_d[i*BCD_W +: BCD_W] = '0;
                        end else begin
                            digits_d[i*BCD_W +: BCD_W] = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == '0) begin
                            digits_d[i*BCD_W +: BCD_W] = BCD_MAX;
                        end else begin
                            digits_d[i*BCD_W +: BCD_W] = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            if (carry) wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits_q  <= '0;
            wrapped_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.wrapped = wrapped_q;

endmodule
